if_fetch_unit: RTL and testbench
================================

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 resetn  in  1  reset, asynchronous assert, active-low.
REQ-003 stall  in  `StallBus  pipeline stall vector; bit1 = IF/ID register hold (`Stop/`NoStop), bit2 = ID hold.
REQ-004 br_bus  in  `BR_WD (33)  {br_e, br_addr[31:0]} from decode; combinational, valid while the branch sits in ID.
REQ-005 inst_req  out  1  SRAM-like fetch request.
REQ-006 inst_wr  out  1  constant 0.
REQ-007 inst_size  out  2  constant 2'b10 (word).
REQ-008 inst_addr  out  32  fetch address.
REQ-009 inst_addr_ok  in  1  request accepted.
REQ-010 inst_data_ok  in  1  read data valid.
REQ-011 inst_rdata  in  32  read data.
REQ-012 if_to_id_bus  out  `IF_TO_ID_WD (33)  {ce, pc[31:0]} of buffered instruction.
REQ-013 if_inst  out  32  buffered instruction word, aligned with if_to_id_bus.
REQ-014 stallreq  out  1  fetch pending, no instruction available.

Function
REQ-015 FSM states: IDLE, REQ, WAIT, HOLD; exactly one fetch outstanding at any time.
REQ-016 IDLE: first cycle after reset release -> REQ; inst_req=0.
REQ-017 REQ: inst_req=1, inst_addr=pc_r held stable until inst_addr_ok=1, then -> WAIT.
REQ-018 WAIT: inst_req=0; on inst_data_ok=1 write buffer {valid=1, pc=pc_r, inst=inst_rdata}, -> HOLD.
REQ-019 HOLD: buffer valid; on an edge with stall[1]==`NoStop buffer drains (valid<=0), pc_r<=next_pc, -> REQ.
REQ-020 if_to_id_bus = {buf_valid, buf_pc}, if_inst = buf_inst; ce=0 whenever buffer empty (decode sees a bubble).
REQ-021 next_pc priority: (br_e & stall[2]==`NoStop) ? br_addr : br_valid ? br_tgt : pc_r+4 (32-bit wrap, carry discarded).
REQ-022 Branch capture: when br_e=1 on an edge with stall[2]==`NoStop, and the buffer does not drain that edge, br_valid<=1, br_tgt<=br_addr.
REQ-023 br_valid clears on the drain edge that consumes it; simultaneous capture and drain uses br_addr directly (REQ-021) and leaves br_valid=0.
REQ-024 br_e while stall[2]==`Stop is ignored (branch held in ID, re-seen later).
REQ-025 next_pc[1:0] forced to 2'b00.
REQ-026 inst_data_ok in IDLE, REQ or HOLD ignored (stale response after reset).
REQ-027 Zero-wait bus: REQ cycle T, data_ok T+1, buffer valid T+2, earliest next request T+3.
REQ-028 stallreq = (state==REQ | state==WAIT) & ~buf_valid.
REQ-029 Delay slot: instruction at branch_pc+4 is always fetched and delivered before the target.

Reset
REQ-030 resetn=0 asynchronously: state=IDLE, pc_r=`RESET_PC (32'hBFC00000), buffer valid/pc/inst=0, br_valid=0, br_tgt=0.
REQ-031 Reset output values: inst_req=0, inst_addr=32'hBFC00000, if_to_id_bus=0, if_inst=0, stallreq=0.
REQ-032 Reset mid-transaction abandons it; first post-reset request is 32'hBFC00000.

Structure
REQ-033 `RESET_PC, `IF_TO_ID_WD, `BR_WD, `StallBus, `Stop/`NoStop and FSM state encodings live in lib/defines.vh.
REQ-034 One sub-module, if_inst_buf: single-entry {valid, pc, inst} register with write/drain controls; FSM and PC logic stay in if_fetch_unit.

Verification
REQ-035 Reset release, zero-wait memory, stall=0 -> inst_addr sequence BFC00000, BFC00004, BFC00008; ce=1 with matching pc every 3rd cycle.
REQ-036 Hold inst_addr_ok=0 for 4 cycles -> inst_req and inst_addr=BFC00000 stable all 4 cycles; stallreq=1 throughout.
REQ-037 Branch at BFC00010 in ID, br_e=1, br_addr=BFC00100, stall=0 -> fetches BFC00014 (delay slot) then BFC00100.
REQ-038 Same branch with stall[1]=Stop, stall[2]=NoStop for 3 cycles -> buffer holds BFC00014; br_valid set; after release next fetch BFC00100, then BFC00104.
REQ-039 resetn low during WAIT, data_ok arrives while IDLE -> ignored; ce stays 0; next request BFC00000.
REQ-040 br_addr=BFC00102 -> issued fetch address BFC00100.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Shared constants, bus widths and FSM encoding for the instruction fetch unit.
// Stall vector bit 1 holds the IF/ID register, bit 2 holds the ID stage.
package if_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC    = 32'hBFC0_0000;
    localparam int          IF_TO_ID_WD = 33;
    localparam int          BR_WD       = 33;
    localparam int          STALL_WD    = 6;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_inst_buf.sv
// Single-entry fetch buffer holding one returned instruction and its PC
// until decode accepts it.
module if_inst_buf (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wr,
    input  logic        drain,
    input  logic [31:0] wr_pc,
    input  logic [31:0] wr_inst,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] inst
);

    // NOTE: a single register entry, so pc/inst are reset too; a RAM-backed queue would not be.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid <= 1'b0;
            pc    <= '0;
            inst  <= '0;
        end else if (wr) begin
            valid <= 1'b1;
            pc    <= wr_pc;
            inst  <= wr_inst;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: one outstanding SRAM-like read at a time, a
// single-entry buffer towards decode, and branch redirection after the delay slot.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
(
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [STALL_WD-1:0]    stall,
    input  logic [BR_WD-1:0]       br_bus,
    output logic                   inst_req,
    output logic                   inst_wr,
    output logic [1:0]             inst_size,
    output logic [31:0]            inst_addr,
    input  logic                   inst_addr_ok,
    input  logic                   inst_data_ok,
    input  logic [31:0]            inst_rdata,
    output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
    output logic [31:0]            if_inst,
    output logic                   stallreq
);

    fetch_state_e state;
    logic [31:0]  pc_r;
    logic         inst_req_r;

    logic         br_e;
    logic [31:0]  br_addr;
    logic         br_take;
    logic         br_valid;
    logic [31:0]  br_tgt;
    logic [31:0]  next_pc_raw;
    logic [31:0]  next_pc;

    logic         buf_wr;
    logic         drain;
    logic         buf_valid;
    logic [31:0]  buf_pc;
    logic [31:0]  buf_inst;

    logic         unused_stall;

    assign br_e         = br_bus[32];
    assign br_addr      = br_bus[31:0];
    assign br_take      = br_e & (stall[2] == NO_STOP);
    assign drain        = (state == HOLD) & (stall[1] == NO_STOP);
    assign buf_wr       = (state == WAIT) & inst_data_ok;
    assign unused_stall = ^{stall[STALL_WD-1:3], stall[0]};

    // A branch seen on the drain edge itself wins over one captured earlier.
    // NOTE: default assignment first so every path drives next_pc_raw and no latch is inferred.
    always_comb begin
        next_pc_raw = pc_r + 32'd4;
        if (br_take) begin
            next_pc_raw = br_addr;
        end else if (br_valid) begin
            next_pc_raw = br_tgt;
        end
    end

    assign next_pc = word_align(next_pc_raw);

    // NOTE: non-blocking assignments so every register samples its peers' pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            pc_r       <= RESET_PC;
            inst_req_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state      <= REQ;
                    inst_req_r <= 1'b1;
                end
                REQ: begin
                    if (inst_addr_ok) begin
                        state      <= WAIT;
                        inst_req_r <= 1'b0;
                    end
                end
                WAIT: begin
                    if (inst_data_ok) begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (drain) begin
                        state      <= REQ;
                        inst_req_r <= 1'b1;
                        pc_r       <= next_pc;
                    end
                end
                default: begin
                    state      <= IDLE;
                    inst_req_r <= 1'b0;
                end
            endcase
        end
    end

    // Remembers a branch resolved while the delay slot is still in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            br_valid <= 1'b0;
            br_tgt   <= '0;
        end else if (drain) begin
            br_valid <= 1'b0;
        end else if (br_take) begin
            br_valid <= 1'b1;
            br_tgt   <= br_addr;
        end
    end

    if_inst_buf u_inst_buf (
        .clk     (clk),
        .resetn  (resetn),
        .wr      (buf_wr),
        .drain   (drain),
        .wr_pc   (pc_r),
        .wr_inst (inst_rdata),
        .valid   (buf_valid),
        .pc      (buf_pc),
        .inst    (buf_inst)
    );

    assign inst_req     = inst_req_r;
    assign inst_wr      = 1'b0;
    assign inst_size    = 2'b10;
    assign inst_addr    = pc_r;
    assign if_to_id_bus = {buf_valid, buf_pc};
    assign if_inst      = buf_inst;
    assign stallreq     = ((state == REQ) | (state == WAIT)) & ~buf_valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: tests queue expected fetch addresses and
// deliveries, a memory model answers requests, monitors compare at negedge.
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    logic                   clk = 1'b0;
    logic                   resetn = 1'b0;
    logic [STALL_WD-1:0]    stall = '0;
    logic [BR_WD-1:0]       br_bus = '0;
    logic                   inst_req;
    logic                   inst_wr;
    logic [1:0]             inst_size;
    logic [31:0]            inst_addr;
    logic                   inst_addr_ok = 1'b0;
    logic                   inst_data_ok = 1'b0;
    logic [31:0]            inst_rdata = '0;
    logic [IF_TO_ID_WD-1:0] if_to_id_bus;
    logic [31:0]            if_inst;
    logic                   stallreq;

    if_fetch_unit dut (
        .clk          (clk),
        .resetn       (resetn),
        .stall        (stall),
        .br_bus       (br_bus),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .if_to_id_bus (if_to_id_bus),
        .if_inst      (if_inst),
        .stallreq     (stallreq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        int          gap;
    } deliv_t;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [31:0] exp_addr[$];
    deliv_t      exp_deliv[$];
    int          grants_left = 0;
    int          data_lat = 1;
    int          dcnt = 0;
    logic [31:0] pend_addr = '0;
    int          last_drain = -1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, expv);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %h, required nothing pending", name, act);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: grants only the scripted number of requests, data after data_lat cycles.
    always @(posedge clk) begin
        #2;
        if (dcnt > 0) begin
            dcnt--;
            inst_data_ok = (dcnt == 0);
            inst_rdata   = (dcnt == 0) ? mem_word(pend_addr) : 32'h0;
        end else begin
            inst_data_ok = 1'b0;
        end
        if (inst_req && grants_left > 0) begin
            inst_addr_ok = 1'b1;
            grants_left--;
            pend_addr = inst_addr;
            dcnt      = data_lat;
        end else begin
            inst_addr_ok = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (resetn && inst_req && inst_addr_ok) begin
            if (exp_addr.size() == 0) begin
                fail_now("unexpected_fetch", {32'h0, inst_addr});
            end else begin
                check("fetch_addr", {32'h0, inst_addr}, {32'h0, exp_addr.pop_front()});
                check("inst_wr", {63'h0, inst_wr}, 64'h0);
                check("inst_size", {62'h0, inst_size}, 64'h2);
            end
        end
    end

    always @(negedge clk) begin : deliv_mon
        deliv_t e;
        if (!resetn) begin
            last_drain = -1;
        end else if (if_to_id_bus[32] && stall[1] == NO_STOP) begin
            if (exp_deliv.size() == 0) begin
                fail_now("unexpected_delivery", {31'h0, if_to_id_bus});
            end else begin
                e = exp_deliv.pop_front();
                check("deliv_pc", {32'h0, if_to_id_bus[31:0]}, {32'h0, e.pc});
                check("deliv_inst", {32'h0, if_inst}, {32'h0, mem_word(e.pc)});
                if (e.gap > 0 && last_drain >= 0)
                    check("drain_gap", 64'(cyc - last_drain), 64'(e.gap));
            end
            last_drain = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input int gap);
        exp_addr.push_back(pc);
        exp_deliv.push_back('{pc: pc, gap: gap});
    endtask

    task automatic do_reset();
        resetn      = 1'b0;
        stall       = '0;
        br_bus      = '0;
        grants_left = 0;
        data_lat    = 1;
        step();
        step();
        check("rst_inst_req", {63'h0, inst_req}, 64'h0);
        check("rst_inst_addr", {32'h0, inst_addr}, {32'h0, RESET_PC});
        check("rst_if_to_id", {31'h0, if_to_id_bus}, 64'h0);
        check("rst_if_inst", {32'h0, if_inst}, 64'h0);
        check("rst_stallreq", {63'h0, stallreq}, 64'h0);
    endtask

    task automatic wait_buf(input logic [31:0] pc);
        int n = 0;
        while (if_to_id_bus !== {1'b1, pc} && n < 60) begin
            step();
            n++;
        end
        if (n >= 60) fail_now("wait_buf_timeout", {32'h0, pc});
    endtask

    task automatic finish_test(input string name);
        int n = 0;
        while ((exp_addr.size() != 0 || exp_deliv.size() != 0) && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) begin
            fail_now({name, "_timeout"}, 64'(exp_addr.size() + exp_deliv.size()));
            exp_addr.delete();
            exp_deliv.delete();
        end
        repeat (4) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Sequential fetch, zero-wait memory: one delivery every 3 cycles.
        do_reset();
        push(32'hBFC0_0000, 0);
        push(32'hBFC0_0004, 3);
        push(32'hBFC0_0008, 3);
        grants_left = 3;
        resetn = 1'b1;
        finish_test("seq");

        // Withheld addr_ok: request and address must stay put.
        do_reset();
        push(32'hBFC0_0000, 0);
        push(32'hBFC0_0004, 3);
        resetn = 1'b1;
        check("idle_req", {63'h0, inst_req}, 64'h0);
        step();
        for (int i = 0; i < 4; i++) begin
            check("hold_req", {63'h0, inst_req}, 64'h1);
            check("hold_addr", {32'h0, inst_addr}, {32'h0, RESET_PC});
            check("hold_stallreq", {63'h0, stallreq}, 64'h1);
            step();
        end
        grants_left = 2;
        finish_test("addr_hold");

        // Branch at BFC00010 in ID: delay slot then target.
        do_reset();
        for (int i = 0; i < 6; i++) push(RESET_PC + 32'(4 * i), (i == 0) ? 0 : 3);
        push(32'hBFC0_0100, 3);
        push(32'hBFC0_0104, 3);
        grants_left = 8;
        resetn = 1'b1;
        wait_buf(32'hBFC0_0010);
        step();
        br_bus = {1'b1, 32'hBFC0_0100};
        step();
        br_bus = '0;
        finish_test("branch");

        // Same branch with the delay slot held in the buffer for 3 cycles.
        do_reset();
        for (int i = 0; i < 5; i++) push(RESET_PC + 32'(4 * i), (i == 0) ? 0 : 3);
        push(32'hBFC0_0014, 6);
        push(32'hBFC0_0100, 3);
        push(32'hBFC0_0104, 3);
        grants_left = 8;
        resetn = 1'b1;
        wait_buf(32'hBFC0_0010);
        step();
        br_bus = {1'b1, 32'hBFC0_0100};
        step();
        br_bus = '0;
        wait_buf(32'hBFC0_0014);
        stall = 6'b000010;
        for (int i = 0; i < 3; i++) begin
            check("stall_buf", {31'h0, if_to_id_bus}, {31'h0, 1'b1, 32'hBFC0_0014});
            check("stall_stallreq", {63'h0, stallreq}, 64'h0);
            step();
        end
        stall = '0;
        finish_test("branch_stall");

        // Branch on the drain edge itself, unaligned target.
        do_reset();
        push(32'hBFC0_0000, 0);
        push(32'hBFC0_0004, 3);
        push(32'hBFC0_0100, 3);
        push(32'hBFC0_0104, 3);
        grants_left = 4;
        resetn = 1'b1;
        wait_buf(32'hBFC0_0004);
        br_bus = {1'b1, 32'hBFC0_0102};
        step();
        br_bus = '0;
        finish_test("branch_unaligned");

        // Target at the top of the address space wraps to zero.
        do_reset();
        push(32'hBFC0_0000, 0);
        push(32'hFFFF_FFFC, 3);
        push(32'h0000_0000, 3);
        grants_left = 3;
        resetn = 1'b1;
        wait_buf(32'hBFC0_0000);
        br_bus = {1'b1, 32'hFFFF_FFFF};
        step();
        br_bus = '0;
        finish_test("pc_wrap");

        // Branch while ID is stalled is ignored.
        do_reset();
        push(32'hBFC0_0000, 0);
        push(32'hBFC0_0004, 3);
        push(32'hBFC0_0008, 3);
        grants_left = 3;
        resetn = 1'b1;
        wait_buf(32'hBFC0_0000);
        step();
        br_bus = {1'b1, 32'hBFC0_0200};
        stall  = 6'b000100;
        step();
        br_bus = '0;
        stall  = '0;
        finish_test("branch_id_stall");

        // Reset during WAIT; the stale data_ok lands in IDLE and is dropped.
        do_reset();
        push(32'hBFC0_0000, 0);
        grants_left = 1;
        data_lat    = 2;
        resetn = 1'b1;
        for (int n = 0; n < 20 && grants_left != 0; n++) step();
        check("grant_seen", 64'(grants_left), 64'h0);
        resetn = 1'b0;
        exp_addr.push_back(RESET_PC);
        step();
        resetn      = 1'b1;
        data_lat    = 1;
        grants_left = 1;
        check("stale_ce_idle", {63'h0, if_to_id_bus[32]}, 64'h0);
        step();
        check("stale_ce_req", {63'h0, if_to_id_bus[32]}, 64'h0);
        check("rerun_req", {63'h0, inst_req}, 64'h1);
        check("rerun_addr", {32'h0, inst_addr}, {32'h0, RESET_PC});
        finish_test("reset_mid");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
